// File: rtl/stream_demux.sv
// stream_demux: 1:N valid/ready stream demultiplexer with a one-entry
// registered slot per output channel, broadcast mode and a saturating
// counter of beats dropped for an out-of-range select.
module stream_demux #(
  parameter  int N_CH  = 8,
  parameter  int DW    = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  output logic [N_CH-1:0]    out_valid,
  input  logic [N_CH-1:0]    out_ready,
  output logic [N_CH*DW-1:0] out_data,
  output logic [7:0]         drop_cnt
);

  logic [N_CH-1:0]          full_q, full_d;
  logic [N_CH-1:0][DW-1:0]  data_q, data_d;
  logic [7:0]               drop_cnt_q, drop_cnt_d;

  logic [N_CH-1:0]          sel_hit;
  logic [N_CH-1:0]          free;
  logic [N_CH-1:0]          load;
  logic                     sel_ok;
  logic                     fire;
  logic                     drop;

  // One-hot decode of the select; an out-of-range select hits no channel,
  // which avoids a magnitude compare that is constant for power-of-2 N_CH.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_sel
    assign sel_hit[gi] = (in_sel == SEL_W'(gi));
  end

  assign sel_ok = |sel_hit;
  // A slot can take a new beat if it is empty or being drained this edge.
  assign free   = ~full_q | out_ready;

  // Input ready: broadcast needs every slot, unicast only its own slot, and
  // an out-of-range beat is always taken so it can be discarded.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & free);
    end
  end

  assign fire = in_valid & in_ready;
  assign drop = fire & ~in_bcast & ~sel_ok;
  assign load = fire ? (in_bcast ? {N_CH{1'b1}} : sel_hit) : '0;

  // Next slot state: load wins over drain, so a simultaneous drain and load
  // replaces the beat with no bubble; the drop counter saturates at 255.
  always_comb begin
    full_d     = load | (full_q & ~out_ready);
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (load[i]) begin
        data_d[i] = in_data;
      end
    end
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Slot and counter registers; reset discards all held beats immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: an 8-channel 16-bit instance driven through a
// queue-based scoreboard (directed cases plus a random soak) and a
// 5-channel instance for out-of-range select dropping and saturation.
module tb_stream_demux;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int N5 = 5;
  localparam int W5 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // 8-channel instance
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [2:0]     in_sel;
  logic           in_bcast;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N*W-1:0] out_data;
  logic [7:0]     drop_cnt;

  // 5-channel instance
  logic             v5;
  logic             rdy5;
  logic [W5-1:0]    d5;
  logic [2:0]       s5;
  logic             b5;
  logic [N5-1:0]    ov5;
  logic [N5-1:0]    or5;
  logic [N5*W5-1:0] od5;
  logic [7:0]       dc5;

  int compared = 0;
  int mismatched = 0;

  // Reference model: per-channel queue of beats accepted but not yet consumed.
  logic [W-1:0] exp_q [N][$];

  always #5 clk = ~clk;

  stream_demux #(.N_CH(N), .DW(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  stream_demux #(.N_CH(N5), .DW(W5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v5), .in_ready(rdy5), .in_data(d5),
    .in_sel(s5), .in_bcast(b5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5),
    .drop_cnt(dc5)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: just before each rising edge compare every channel against the
  // head of its expected queue and retire the beat when the consumer takes it.
  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          exp_v = (exp_q[i].size() != 0);
          if (out_valid[i] || exp_v) begin
            check($sformatf("ch%0d_valid", i), 64'(out_valid[i]), 64'(exp_v));
            if (out_valid[i] && exp_v) begin
              check($sformatf("ch%0d_data", i), 64'(out_data[i*W +: W]), 64'(exp_q[i][0]));
              if (out_ready[i]) void'(exp_q[i].pop_front());
            end
          end
        end
      end
    end
  end

  // After the monitor has retired drained beats, a slot is free exactly when
  // its queue is empty. Check in_ready against that and record any accept.
  task automatic step(output logic fired);
    logic exp_rdy;
    #2;
    exp_rdy = 1'b1;
    if (in_bcast) begin
      for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) exp_rdy = 1'b0;
    end else if (exp_q[in_sel].size() != 0) begin
      exp_rdy = 1'b0;
    end
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    fired = in_valid && in_ready;
    if (fired) begin
      if (in_bcast) begin
        for (int i = 0; i < N; i++) exp_q[i].push_back(in_data);
      end else begin
        exp_q[in_sel].push_back(in_data);
      end
    end
  endtask

  // Offer one beat until accepted; consumers in stall_mask are held not-ready
  // for the first stall_cycles cycles, everyone else is ready.
  task automatic send(input logic [W-1:0] d, input int sel, input logic bc,
                      input logic [N-1:0] stall_mask, input int stall_cycles);
    logic f;
    f = 1'b0;
    for (int c = 0; c < 20 && !f; c++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_sel    = 3'(sel);
      in_bcast  = bc;
      out_ready = (c < stall_cycles) ? ~stall_mask : '1;
      step(f);
    end
    check("send_accepted", 64'(f), 64'd1);
  endtask

  task automatic idle(input int n, input logic [N-1:0] rdy);
    logic f;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = rdy;
      step(f);
    end
  endtask

  initial begin
    logic f;
    in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;
    v5 = 1'b0; d5 = '0; s5 = '0; b5 = 1'b0; or5 = '0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data_nz", 64'(|out_data), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst5_in_ready", 64'(rdy5), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Unicast 0..7 to channels 0..7, all consumers ready
    for (int i = 0; i < N; i++) send(W'(i), i, 1'b0, '0, 0);
    idle(2, '1);
    check("drop_cnt_unicast", 64'(drop_cnt), 64'd0);

    // Channel 3 stalled: second beat waits, then replaces the first with no bubble
    send(16'h00A1, 3, 1'b0, 8'h08, 1);
    send(16'h00A2, 3, 1'b0, 8'h08, 3);
    idle(2, '1);

    // Broadcast blocked by a full, stalled channel 6, then delivered to all
    send(16'h0066, 6, 1'b0, 8'h40, 1);
    send(16'h005C, 0, 1'b1, 8'h40, 3);
    idle(2, '1);

    // Out-of-range selects on the 5-channel instance
    @(negedge clk);
    v5 = 1'b1; d5 = 8'h22; s5 = 3'd2; b5 = 1'b0; or5 = '0;
    #2 check("d5_rdy_sel2", 64'(rdy5), 64'd1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      s5 = 3'd6; d5 = 8'h60 + 8'(j);
      #2;
      check("d5_rdy_bad", 64'(rdy5), 64'd1);
      check("d5_valid_hold", 64'(ov5), 64'h04);
      check("d5_data_ch2", 64'(od5[2*W5 +: W5]), 64'h22);
      check("d5_drop_cnt", 64'(dc5), 64'(j));
    end
    @(negedge clk);
    v5 = 1'b0; or5 = '1;
    #2;
    check("d5_drop_cnt3", 64'(dc5), 64'd3);
    check("d5_valid_ch2", 64'(ov5), 64'h04);
    @(negedge clk);
    #2 check("d5_valid_drained", 64'(ov5), 64'd0);
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      v5 = 1'b1; b5 = 1'b0; s5 = 3'($urandom_range(5, 7)); d5 = 8'($urandom);
    end
    @(negedge clk);
    v5 = 1'b0;
    #2;
    check("d5_drop_sat", 64'(dc5), 64'd255);
    check("d5_valid_after_drops", 64'(ov5), 64'd0);

    // Random soak with producer holding an unaccepted beat stable
    in_valid = 1'b0;
    f = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (!(in_valid && !f)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = W'($urandom);
        in_sel   = 3'($urandom_range(0, 7));
        in_bcast = ($urandom_range(0, 7) == 0);
      end
      out_ready = N'($urandom | $urandom);
      step(f);
    end
    idle(4, '1);
    for (int i = 0; i < N; i++) check($sformatf("drain_ch%0d", i), 64'(exp_q[i].size()), 64'd0);
    check("drop_cnt_soak", 64'(drop_cnt), 64'd0);

    // Fill channels 0..2 with consumers stalled, then reset between edges
    send(16'h0100, 0, 1'b0, '1, 20);
    send(16'h0101, 1, 1'b0, '1, 20);
    send(16'h0102, 2, 1'b0, '1, 20);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data_nz", 64'(|out_data), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("mid_rst_drop_cnt5", 64'(dc5), 64'd0);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0; in_sel = 3'd0; in_bcast = 1'b0; out_ready = '0;
    #2 check("post_rst_in_ready", 64'(in_ready), 64'd1);
    idle(2, '1);
    send(16'h0BEE, 5, 1'b0, '0, 0);
    idle(2, '1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised 1:N stream demultiplexer with a one-entry registered output slot per channel. It routes each accepted input beat to the channel named by `in_sel`, or to all channels in broadcast mode, using valid/ready handshakes on every port. Beats with an out-of-range select are dropped and counted. It sits between a single producer and N independent consumers; it is the successor of the combinational 1:8 demux.

## Interface
- `N_CH`, 8: number of output channels, 2..64.
- `DW`, 8: data width in bits, ≥1.
- `SEL_W`, `$clog2(N_CH)`: select width. Derived; do not override.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: input beat accepted this cycle when high together with `in_valid`.
- `in_data` input DW: input payload.
- `in_sel` input SEL_W: destination channel, used when `in_bcast`=0.
- `in_bcast` input 1: deliver the beat to all N_CH channels.
- `out_valid` output N_CH: bit i means channel i slot holds a beat.
- `out_ready` input N_CH: bit i means consumer i takes the beat.
- `out_data` output N_CH*DW: channel i payload in bits [i*DW +: DW].
- `drop_cnt` output 8: number of beats dropped for an out-of-range select. Saturates at 255.

## Operation
- Each channel has a slot: `full[i]` plus a DW data register. `out_valid[i]` = `full[i]`; `out_data` slice i = data register i.
- A slot is free when it is empty or drained this cycle: `free[i]` = `!full[i] | out_ready[i]`.
- `in_ready` is combinational from the current state and the input control:
  - `in_bcast`=1: `in_ready` = AND of all `free[i]`.
  - `in_bcast`=0 and `in_sel` < N_CH: `in_ready` = `free[in_sel]`.
  - `in_bcast`=0 and `in_sel` ≥ N_CH (possible only when N_CH is not a power of 2): `in_ready` = 1. The beat is dropped.
- Accept condition: `fire` = `in_valid & in_ready`.
- Per channel i on each edge:
  - Load: `fire` targets i, or `fire & in_bcast`. Then `full[i]`←1 and data←`in_data`.
  - Drain: `full[i] & out_ready[i]` and no load. Then `full[i]`←0.
  - Load together with drain: the slot is replaced with the new beat and `full[i]` stays 1. There is no bubble.
  - Otherwise the slot holds. Data and valid stay stable while `out_valid[i]` & !`out_ready[i]`.
- Drop counter: increments on `fire` with `in_bcast`=0 and `in_sel` ≥ N_CH. Holds at 255.
- Producer rules:
  - `in_sel`, `in_bcast` and `in_data` must stay stable while `in_valid`=1 and `in_ready`=0.
  - `in_valid` must not drop before acceptance. Violating either rule is undefined.
- Broadcast is all-or-nothing. A broadcast beat is never partially delivered.
- Channels are independent. A stalled channel blocks only unicasts to itself and broadcasts.
- `in_ready` does not depend on `in_valid`, so there is no valid→ready loop inside the block.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - all `full` bits ← 0, so `out_valid` = 0;
  - all data registers ← 0, so `out_data` = 0;
  - `drop_cnt` ← 0.
  - `in_ready` then follows the combinational rules with every slot free, so it is 1.
- Reset asserted mid-transfer discards every held beat immediately, without waiting for a clock edge.
- Release of `rst_n` is synchronous to `clk` by system convention. The first accept can occur on the first edge after release.
- Latency: a beat accepted at edge k appears on `out_valid`/`out_data` right after edge k, which is one cycle.
- Throughput: one beat per cycle per channel when the consumer holds `out_ready`=1. A broadcast stream runs at one beat per cycle when all consumers are ready.
- Handshakes are evaluated only at rising edges. `out_ready` while `out_valid`=0 has no effect.

## Test plan
- Reset, then send data 0x00..0x07 unicast to sel 0..7, one per cycle, with all `out_ready`=1. Each `out_valid[i]` must pulse for one cycle, one cycle after acceptance, carrying data i. `in_ready` stays 1 and `drop_cnt`=0.
- Hold `out_ready[3]`=0 and send two beats to channel 3 (0xA1, 0xA2). The first is accepted. `in_ready`=0 for the second. `out_data[3]` holds 0xA1 stable. Raising `out_ready[3]` must accept 0xA2 in the same cycle with no bubble.
- Broadcast 0x5C with `out_ready`=all 1 except channel 6=0 while channel 6 is full. `in_ready` stays 0 and no channel loads. Releasing channel 6 must load 0x5C into all 8 slots on the same edge.
- Set N_CH=5 and send sel=6 three times, then sel=2. The sel=6 beats are accepted immediately with no `out_valid` change and `drop_cnt`=3. The sel=2 beat goes to channel 2. Driving 300 bad beats must leave `drop_cnt`=255.
- Fill channels 0, 1 and 2 with all `out_ready`=0, then pulse `rst_n`=0 between clock edges. `out_valid` and `out_data` must go to 0 immediately, `drop_cnt`=0, and `in_ready`=1 after release.
- Random soak: N_CH=8 and DW=16, random valid/ready/bcast/sel for 10k cycles. A scoreboard checks per-channel in-order delivery, no loss and no duplication. Broadcast beats must reach every channel exactly once.
